// File: rtl/hazard_forward_ctrl.sv
// Pipeline sequencer: shadow EX/MEM/WB tracking, forwarding selects, stall/flush/wait control.
// Optional saturating performance counters when HAZ_PERF_CNT_EN is defined.
module hazard_forward_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_enable,
  input  logic             id_load_instr,
  input  logic             id_ls_instr,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic [1:0]       s_pa,
  output logic [1:0]       s_pb,
  output logic [1:0]       s_pd,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             idex_le,
  output logic             exmem_le,
  output logic             memwb_le,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             memwb_bubble
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic       we;
    logic       load;
    logic       ls;
  } stage_t;

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e state_q, state_d;
  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d, mem_d, wb_d;
  stage_t id_stage;

  logic load_use, branch_flush, mem_wait;

  function automatic logic hit(input logic use_src, input logic [3:0] src, input stage_t s);
    return use_src && (src != 4'd15) && s.valid && s.we && (s.rd == src);
  endfunction

  // Load in EX is skipped here; the stall covers it and the result later comes from MEM.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [3:0] src,
                                         input stage_t ex, input stage_t mem, input stage_t wb);
    if (hit(use_src, src, ex) && !ex.load) return 2'b01;
    if (hit(use_src, src, mem))            return 2'b10;
    if (hit(use_src, src, wb))             return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    id_stage = '0;
    if (id_valid) begin
      id_stage = '{valid: 1'b1, rd: id_rd, we: id_rf_enable, load: id_load_instr,
                   ls: id_ls_instr};
    end
  end

  assign load_use = ex_q.valid && ex_q.load && ex_q.we &&
                    (hit(id_use_rn, id_rn, ex_q) || hit(id_use_rm, id_rm, ex_q) ||
                     hit(id_use_rd, id_rd, ex_q));
  assign branch_flush = ex_branch_taken && ex_q.valid;

  // MEM is frozen while waiting, so the same access keeps the wait asserted until ready.
  always_comb begin
    mem_wait = 1'b0;
    unique case (state_q)
      StRun:     mem_wait = mem_q.valid && mem_q.ls && !mem_ready;
      StMemWait: mem_wait = !mem_ready;
      default:   mem_wait = 1'b0;
    endcase
    state_d = mem_wait ? StMemWait : StRun;
  end

  always_comb begin
    s_pa         = 2'b00;
    s_pb         = 2'b00;
    s_pd         = 2'b00;
    pc_le        = 1'b0;
    ifid_le      = 1'b0;
    idex_le      = 1'b0;
    exmem_le     = 1'b0;
    memwb_le     = 1'b0;
    idex_bubble  = 1'b1;
    ifid_flush   = 1'b1;
    memwb_bubble = 1'b1;
    if (reset) begin
      s_pa = fwd_sel(id_use_rn, id_rn, ex_q, mem_q, wb_q);
      s_pb = fwd_sel(id_use_rm, id_rm, ex_q, mem_q, wb_q);
      s_pd = fwd_sel(id_use_rd, id_rd, ex_q, mem_q, wb_q);
      if (mem_wait) begin
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        memwb_bubble = 1'b1;
      end else begin
        pc_le        = 1'b1;
        ifid_le      = 1'b1;
        idex_le      = 1'b1;
        exmem_le     = 1'b1;
        memwb_le     = 1'b1;
        memwb_bubble = 1'b0;
        ifid_flush   = branch_flush;
        idex_bubble  = branch_flush || load_use;
        if (load_use && !branch_flush) begin
          pc_le   = 1'b0;
          ifid_le = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = memwb_bubble ? '0 : mem_q;
    if (!mem_wait) begin
      ex_d  = idex_bubble ? '0 : id_stage;
      mem_d = ex_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic stall_evt;
  assign stall_evt = load_use && !branch_flush && !mem_wait;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (mem_wait && (wait_cnt != '1))   wait_cnt  <= wait_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios then random traffic,
// every cycle compared against a stage-list reference model.
module tb_hazard_forward_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rn, id_use_rm, id_use_rd;
  logic [3:0] id_rn, id_rm, id_rd;
  logic id_rf_enable, id_load_instr, id_ls_instr, ex_branch_taken, mem_ready;
  logic [1:0] s_pa, s_pb, s_pd;
  logic pc_le, ifid_le, idex_le, exmem_le, memwb_le;
  logic idex_bubble, ifid_flush, memwb_bubble;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(rst_n),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr), .id_ls_instr(id_ls_instr),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .s_pa(s_pa), .s_pb(s_pb), .s_pd(s_pd),
    .pc_le(pc_le), .ifid_le(ifid_le), .idex_le(idex_le), .exmem_le(exmem_le),
    .memwb_le(memwb_le), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .memwb_bubble(memwb_bubble)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
`endif
  );

  // Reference model: st[0]=EX, st[1]=MEM, st[2]=WB.
  typedef struct {bit v; int rd; bit we; bit ld; bit ls;} ent_t;
  ent_t st[3];
  int m_stall, m_flush, m_wait;

  function automatic ent_t zero_ent();
    ent_t z;
    z = '{v: 0, rd: 0, we: 0, ld: 0, ls: 0};
    return z;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) st[i] = zero_ent();
    m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  function automatic logic [1:0] exp_sel(input bit u, input int idx);
    if (!u || idx == 15) return 2'b00;
    for (int s = 0; s < 3; s++)
      if (st[s].v && st[s].we && st[s].rd == idx && !(s == 0 && st[s].ld))
        return 2'(s + 1);
    return 2'b00;
  endfunction

  function automatic bit src_is_load(input bit u, input int idx);
    return u && idx != 15 && idx == st[0].rd;
  endfunction

  function automatic bit m_is_wait();
    return st[1].v && st[1].ls && !mem_ready;
  endfunction

  function automatic bit m_is_flush();
    return ex_branch_taken && st[0].v;
  endfunction

  function automatic bit m_is_stall();
    return st[0].v && st[0].ld && st[0].we &&
           (src_is_load(id_use_rn, int'(id_rn)) || src_is_load(id_use_rm, int'(id_rm)) ||
            src_is_load(id_use_rd, int'(id_rd)));
  endfunction

  // {s_pa, s_pb, s_pd, pc, ifid, idex, exmem, memwb, idex_bubble, ifid_flush, memwb_bubble}
  function automatic logic [13:0] exp_out();
    logic [5:0] sel;
    if (!rst_n) return {6'b0, 5'b00000, 3'b111};
    sel = {exp_sel(id_use_rn, int'(id_rn)), exp_sel(id_use_rm, int'(id_rm)),
           exp_sel(id_use_rd, int'(id_rd))};
    if (m_is_wait())  return {sel, 5'b00000, 3'b001};
    if (m_is_flush()) return {sel, 5'b11111, 3'b110};
    if (m_is_stall()) return {sel, 5'b00111, 3'b100};
    return {sel, 5'b11111, 3'b000};
  endfunction

  task automatic model_step();
    bit w, f, s;
    ent_t n;
    w = m_is_wait(); f = m_is_flush(); s = m_is_stall();
    if (s && !f && !w && m_stall < 65535) m_stall++;
    if (f && !w && m_flush < 65535) m_flush++;
    if (w && m_wait < 65535) m_wait++;
    n = zero_ent();
    if (id_valid)
      n = '{v: 1, rd: int'(id_rd), we: id_rf_enable, ld: id_load_instr, ls: id_ls_instr};
    if (w) begin
      st[2] = zero_ent();
    end else begin
      st[2] = st[1];
      st[1] = st[0];
      st[0] = (f || s) ? zero_ent() : n;
    end
  endtask

  task automatic check(input string tag);
    logic [13:0] obs, expv;
    obs = {s_pa, s_pb, s_pd, pc_le, ifid_le, idex_le, exmem_le, memwb_le,
           idex_bubble, ifid_flush, memwb_bubble};
    expv = exp_out();
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: outputs got %b want %b", tag, obs, expv);
    end
`ifdef HAZ_PERF_CNT_EN
    compared++;
    assert ({stall_cnt, flush_cnt, wait_cnt} === {16'(m_stall), 16'(m_flush), 16'(m_wait)})
    else begin
      mismatched++;
      $error("FAIL %s_cnt: got %0d/%0d/%0d want %0d/%0d/%0d", tag, stall_cnt, flush_cnt,
             wait_cnt, m_stall, m_flush, m_wait);
    end
`endif
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    if (rst_n) model_step();
    else model_clear();
    #1;
  endtask

  task automatic set_id(input bit v, input int rn, input int rm, input int rd, input bit urn,
                        input bit urm, input bit urd, input bit we, input bit ld,
                        input bit ls);
    id_valid = v; id_rn = 4'(rn); id_rm = 4'(rm); id_rd = 4'(rd);
    id_use_rn = urn; id_use_rm = urm; id_use_rd = urd;
    id_rf_enable = we; id_load_instr = ld; id_ls_instr = ls;
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b0; ex_branch_taken = 1'b0; mem_ready = 1'b1;
    set_nop();
    model_clear();
    #1;
    cycle("reset");
    rst_n = 1'b1;
    set_nop();                                 cycle("idle");
    set_id(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);      cycle("add_r1");
    set_id(1, 1, 5, 6, 1, 1, 0, 1, 0, 0);      cycle("ex_fwd");
    set_id(1, 0, 0, 2, 0, 0, 0, 1, 0, 0);      cycle("w2a");
                                               cycle("w2b");
    set_nop();                                 cycle("w2_nop");
    set_id(1, 7, 2, 2, 1, 1, 1, 0, 0, 1);      cycle("mem_over_wb");
    set_id(1, 0, 0, 3, 0, 0, 0, 1, 1, 1);      cycle("ldr_r3");
    set_id(1, 3, 0, 8, 1, 0, 0, 1, 0, 0);      cycle("lu_stall");
                                               cycle("lu_after");
    set_id(1, 0, 0, 3, 0, 0, 0, 1, 1, 1);      cycle("ldr_r3b");
    set_id(1, 3, 0, 8, 1, 0, 0, 1, 0, 0);
    ex_branch_taken = 1'b1;                    cycle("br_vs_stall");
    ex_branch_taken = 1'b0;
    set_id(1, 0, 0, 4, 0, 0, 1, 0, 0, 1);      cycle("str_r4");
    set_nop();                                 cycle("str_nop");
    mem_ready = 1'b0;
    repeat (3)                                 cycle("mwait");
    mem_ready = 1'b1;                          cycle("mwait_rel");
    set_id(1, 0, 0, 4, 0, 0, 1, 0, 0, 1);      cycle("str2");
    set_nop();                                 cycle("str2_nop");
    mem_ready = 1'b0;                          cycle("mwait2");
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rst_mid_wait");
    @(posedge clk);
    #1;
    rst_n = 1'b1;                              cycle("post_rst_run");
    mem_ready = 1'b1;

    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      if (!rst_n) model_clear();
      set_id($urandom_range(0, 3) != 0, rnd_reg(), rnd_reg(), rnd_reg(),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline sequencer for the five-stage ARM datapath (IF, ID, EX, MEM, WB). It keeps its own shadow pipeline of destination-register and control bits for each stage and drives the PA/PB/PD forwarding mux selects. It also drives the stage latch enables, the load-use bubble, the branch flush and the data-memory wait freeze. It replaces the stateless hazard detector, so the datapath only supplies ID decode fields, the EX branch decision and the memory ready flag.

## Interface
- CNT_W, 16, width of the performance counters; used only when HAZ_PERF_CNT_EN is defined.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- id_valid  in  1  ID holds a real instruction
- id_rn, id_rm, id_rd  in  4 each  ID source registers; id_rd is read through PD for stores and for the shifter Rm path
- id_use_rn, id_use_rm, id_use_rd  in  1 each  the matching source is actually read
- id_rf_enable  in  1  ID instruction writes id_rd
- id_load_instr  in  1  ID instruction is a load
- id_ls_instr  in  1  ID instruction is a load or a store
- ex_branch_taken  in  1  branch/BL in EX resolved taken (ConditionHandler)
- mem_ready  in  1  data memory has completed the MEM-stage access
- s_pa, s_pb, s_pd  out  2 each  forwarding select: 00 register file, 01 EX result, 10 MEM result, 11 WB data
- pc_le, ifid_le  out  1 each  PC and IF/ID latch enables
- idex_le, exmem_le, memwb_le  out  1 each  stage latch enables
- idex_bubble  out  1  load a NOP into ID/EX this edge
- ifid_flush  out  1  load a NOP into IF/ID this edge
- memwb_bubble  out  1  load a NOP into MEM/WB this edge
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  present only with HAZ_PERF_CNT_EN

## Operation
- **Shadow stages.** EX, MEM and WB each hold {valid, rd[3:0], we, load, ls}. All are cleared to 0 by reset.
- **Forwarding.** For each used source with register index not equal to R15, compare against the shadow stages in priority order EX, then MEM, then WB. The first stage that is valid with we=1 and a matching rd selects the path. Otherwise, or when the source is unused, the select is 00.
- **Load in EX.** A load in EX never forwards through the EX path, because that case produces a load-use stall.
- **Load-use stall.** Condition: EX.valid & EX.load & EX.we, and the EX rd matches any used ID source other than R15. Response:
  - pc_le = 0, ifid_le = 0
  - idex_bubble = 1
  - EX, MEM and WB still advance.
- **Branch flush.** ex_branch_taken & EX.valid gives ifid_flush = 1 and idex_bubble = 1. The instruction in ID is squashed.
  - Branch flush overrides a simultaneous load-use stall: no stall is raised and the PC loads the target.
- **FSM states.**
  - RUN → MEM_WAIT when MEM.valid & MEM.ls & !mem_ready.
  - MEM_WAIT → RUN when mem_ready = 1.
  - The wait decision is combinational on mem_ready, so a zero-wait access never leaves RUN.
- **Freeze while waiting.** While waiting, all latch enables are 0, idex_bubble = 0, ifid_flush = 0, and memwb_bubble = 1 (WB retires a NOP).
  - Wait overrides both stall and flush.
  - A taken branch held in EX raises ifid_flush on the first cycle after the wait releases.
- **Shadow update on an advancing edge.**
  - ID→EX: takes the ID fields, or zeros when bubbled or flushed.
  - EX→MEM and MEM→WB shift normally.
  - MEM→WB is zeroed when memwb_bubble = 1.
- **Idle.** With no hazard, all enables are 1 and all bubbles are 0.

## Timing
- Selects, enables, bubble and flush outputs are combinational from the shadow registers, the ID inputs, ex_branch_taken and mem_ready. Each is valid in the same cycle as its inputs.
- Load-use costs exactly one bubble. The consumer then sees the load in MEM and gets s_* = 10.
- A taken branch costs one flushed slot plus one bubble.
- Each MEM_WAIT cycle adds one cycle of latency.
- **While reset = 0:**
  - shadow registers are cleared and the FSM is in RUN;
  - s_* = 00;
  - all latch enables = 0;
  - idex_bubble = 1, ifid_flush = 1, memwb_bubble = 1;
  - counters = 0.
- Deasserting reset lets the first edge advance normally.
- Reset asserted mid-wait returns the FSM to RUN immediately.

## Configuration
- **HAZ_PERF_CNT_EN defined:** three saturating CNT_W counters are added. Each increments on the clock edge at the end of a cycle in which its condition holds:
  - stall_cnt: each load-use stall cycle;
  - flush_cnt: each ifid_flush cycle;
  - wait_cnt: each MEM_WAIT freeze cycle.
  - Each counter holds at its all-ones value.
- **Not defined:** the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **EX forwarding.** ADD R1 (EX, we) while ID ADD reads R1 on Rn → s_pa = 01, s_pb = 00, all enables 1.
- **MEM over WB.** R2 is written in MEM and also in WB while ID reads R2 on Rm and Rd → s_pb = 10, s_pd = 10.
- **Load-use.** LDR R3 in EX while ID reads R3 → one cycle with pc_le = 0, idex_bubble = 1. Next cycle s_pa = 10 and stall_cnt = 1.
- **Branch vs. stall.** Taken branch in EX coinciding with a load-use condition → ifid_flush = 1, idex_bubble = 1, pc_le = 1, no stall counted.
- **Memory wait.** STR in MEM with mem_ready low for 3 cycles → 3 cycles with all enables 0 and memwb_bubble = 1, then RUN. wait_cnt = 3.
- **Reset mid-wait.** reset = 0 during MEM_WAIT → outputs go to reset values without a clock edge. After release, the FSM is in RUN.
